// File: rtl/sched_pkg.sv
// Shared state encoding and bit-index width for the detector frame scheduler.
package sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int IDX_W = 5;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on contention the requester not served last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // r_last=1 means requester 1 was served last, so requester 0 is favoured after reset
  logic r_last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_last <= 1'b1;
    else if (en && (gnt != 2'b00))
      r_last <= gnt[1];
  end

endmodule

// File: rtl/detector_frame_sched.sv
// Serialises frames from two requesters into one shared sequence detector and counts its hits.
// Optional macro SCHED_EARLY_STOP_EN: finish the frame at the first detector hit.
module detector_frame_sched
  import sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       ack,
  output logic             det_x,
  output logic             det_rst,
  input  logic             det_f,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [IDX_W-1:0] hit_pos
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] r_first;
  logic [CNT_W-1:0] r_cnt;
  logic             r_seen;
  logic             r_id;
  logic             r_done_id;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [IDX_W-1:0] r_hit_pos;

  logic             w_arb_en;
  logic [1:0]       w_gnt;
  logic             w_smp;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_first_nxt;

  assign w_arb_en = (r_state == ST_IDLE) && !rst;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (w_arb_en),
    .gnt (w_gnt)
  );

  assign ack     = w_arb_en ? w_gnt : 2'b00;
  assign det_rst = rst | (r_state == ST_CLR);
  assign det_x   = (r_state == ST_SHIFT) & r_shreg[WIDTH-1];
  assign done    = (r_state == ST_DONE);
  assign done_id = r_done_id;
  assign hit_cnt = r_hit_cnt;
  assign hit_pos = r_hit_pos;

  // F lags x by one cycle: the sample taken at shift index k belongs to bit k-1, DRAIN holds the last bit
  assign w_smp       = ((r_state == ST_SHIFT) && (r_k != '0)) || (r_state == ST_DRAIN);
  assign w_hit       = w_smp && det_f;
  assign w_idx       = (r_state == ST_DRAIN) ? IDX_W'(WIDTH - 1) : r_k - 1'b1;
  assign w_cnt_nxt   = w_hit ? sat_inc(r_cnt) : r_cnt;
  assign w_first_nxt = (w_hit && !r_seen) ? w_idx : r_first;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_done_id <= 1'b0;
      r_hit_cnt <= '0;
      r_hit_pos <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt != 2'b00) begin
            r_shreg <= w_gnt[0] ? data0 : data1;
            r_id    <= w_gnt[1];
            r_state <= ST_CLR;
          end
        end
        ST_CLR: begin
          r_cnt   <= '0;
          r_k     <= '0;
          r_seen  <= 1'b0;
          r_first <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_shreg <= r_shreg << 1;
          r_k     <= r_k + 1'b1;
          r_cnt   <= w_cnt_nxt;
          r_seen  <= r_seen | w_hit;
          r_first <= w_first_nxt;
`ifdef SCHED_EARLY_STOP_EN
          if (w_hit) begin
            r_state   <= ST_DONE;
            r_done_id <= r_id;
            r_hit_cnt <= w_cnt_nxt;
            r_hit_pos <= w_first_nxt;
          end else if (r_k == IDX_W'(WIDTH - 1)) begin
            r_state <= ST_DRAIN;
          end
`else
          if (r_k == IDX_W'(WIDTH - 1))
            r_state <= ST_DRAIN;
`endif
        end
        ST_DRAIN: begin
          r_state   <= ST_DONE;
          r_done_id <= r_id;
          r_hit_cnt <= w_cnt_nxt;
          r_hit_pos <= w_first_nxt;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detector_frame_sched.sv
// Directed bench for detector_frame_sched with a registered-x stub detector (hit count = popcount).
module tb_detector_frame_sched;

`ifdef SCHED_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [7:0] data0, data1;

  logic [1:0] ack, ack_b;
  logic       det_x, det_rst, det_f, done, done_id;
  logic       det_x_b, det_rst_b, det_f_b, done_b, done_id_b;
  logic [3:0] hit_cnt;
  logic [1:0] hit_cnt_b;
  logic [4:0] hit_pos, hit_pos_b;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  detector_frame_sched #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
    .ack(ack), .det_x(det_x), .det_rst(det_rst), .det_f(det_f),
    .done(done), .done_id(done_id), .hit_cnt(hit_cnt), .hit_pos(hit_pos)
  );

  detector_frame_sched #(.WIDTH(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
    .ack(ack_b), .det_x(det_x_b), .det_rst(det_rst_b), .det_f(det_f_b),
    .done(done_b), .done_id(done_id_b), .hit_cnt(hit_cnt_b), .hit_pos(hit_pos_b)
  );

  always_ff @(posedge clk) begin
    det_f   <= det_rst   ? 1'b0 : det_x;
    det_f_b <= det_rst_b ? 1'b0 : det_x_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic serve(output int t, output logic [1:0] a);
    t = -1000;
    a = 2'b00;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        t = cyc;
        a = ack;
        break;
      end
    end
    @(posedge clk);
    #1;
    req = req & ~a;
  endtask

  task automatic wait_done(output int t);
    t = -1000;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req   = 2'b01;
    data0 = 8'hFF;
    @(negedge clk);
    total++;
    if (ack !== 2'b00 || done !== 1'b0 || det_x !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: ack=%b done=%b det_x=%b, need 00 0 0", ack, done, det_x);
    end
    total++;
    if (done_id !== 1'b0 || hit_cnt !== 4'd0 || hit_pos !== 5'd0) begin
      bad++;
      $display("FAIL reset_result: id=%b cnt=%0d pos=%0d, need 0 0 0", done_id, hit_cnt, hit_pos);
    end
    total++;
    if (det_rst !== 1'b1) begin
      bad++;
      $display("FAIL reset_det_rst: det_rst=%b, need 1", det_rst);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req = 2'b00;
  endtask

  task automatic test_both();
    int ta, td, ta2, td2;
    logic [1:0] a;
    do_reset();
    data0 = 8'hFF;
    data1 = 8'h01;
    req   = 2'b11;
    serve(ta, a);
    total++;
    if (a !== 2'b01) begin bad++; $display("FAIL both_first_grant: ack=%b, need 01", a); end
    wait_done(td);
    total++;
    if (done_id !== 1'b0 || hit_cnt !== (EARLY ? 4'd1 : 4'd8) || hit_pos !== 5'd0) begin
      bad++;
      $display("FAIL both_res0: id=%b cnt=%0d pos=%0d, need 0 %0d 0", done_id, hit_cnt, hit_pos, EARLY ? 1 : 8);
    end
    serve(ta2, a);
    total++;
    if (a !== 2'b10 || ta2 !== td + 1) begin
      bad++;
      $display("FAIL both_second_grant: ack=%b at %0d, need 10 at %0d", a, ta2, td + 1);
    end
    wait_done(td2);
    total++;
    if (done_id !== 1'b1 || hit_cnt !== 4'd1 || hit_pos !== 5'd7 || td2 - ta2 !== 11) begin
      bad++;
      $display("FAIL both_res1: id=%b cnt=%0d pos=%0d lat=%0d, need 1 1 7 11", done_id, hit_cnt, hit_pos, td2 - ta2);
    end
  endtask

  task automatic test_single();
    int ta, td;
    logic [1:0] a;
    data0 = 8'hA5;
    req   = 2'b01;
    serve(ta, a);
    total++;
    if (a !== 2'b01) begin bad++; $display("FAIL single_ack: ack=%b, need 01", a); end
    @(negedge clk);
    total++;
    if (det_rst !== 1'b1) begin bad++; $display("FAIL single_clr: det_rst=%b at T+1, need 1", det_rst); end
    wait_done(td);
    total++;
    if (td - ta !== (EARLY ? 4 : 11)) begin
      bad++;
      $display("FAIL single_latency: %0d, need %0d", td - ta, EARLY ? 4 : 11);
    end
    total++;
    if (done_id !== 1'b0 || hit_cnt !== (EARLY ? 4'd1 : 4'd4) || hit_pos !== 5'd0) begin
      bad++;
      $display("FAIL single_res: id=%b cnt=%0d pos=%0d, need 0 %0d 0", done_id, hit_cnt, hit_pos, EARLY ? 1 : 4);
    end
  endtask

  task automatic test_fair();
    int ta, td;
    logic [1:0] a;
    do_reset();
    data0 = 8'h3C;
    data1 = 8'h81;
    req   = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serve(ta, a);
      if (i < 3) req = 2'b11;
      else       req = 2'b00;
      total++;
      if (a !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL fair_grant%0d: ack=%b, need %b", i, a, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      wait_done(td);
      total++;
      if (done_id !== logic'(i % 2) || hit_cnt !== (EARLY ? 4'd1 : ((i % 2 == 0) ? 4'd4 : 4'd2))) begin
        bad++;
        $display("FAIL fair_done%0d: id=%b cnt=%0d, need %0d", i, done_id, hit_cnt, i % 2);
      end
    end
  endtask

  task automatic test_saturate();
    int ta, td;
    logic [1:0] a;
    data0 = 8'hFF;
    req   = 2'b01;
    serve(ta, a);
    wait_done(td);
    total++;
    if (done_b !== 1'b1 || hit_cnt_b !== (EARLY ? 2'd1 : 2'd3)) begin
      bad++;
      $display("FAIL sat_cnt2: done=%b cnt=%0d, need 1 %0d", done_b, hit_cnt_b, EARLY ? 1 : 3);
    end
    total++;
    if (hit_cnt !== (EARLY ? 4'd1 : 4'd8) || hit_pos_b !== 5'd0) begin
      bad++;
      $display("FAIL sat_cnt4: cnt=%0d pos_b=%0d, need %0d 0", hit_cnt, hit_pos_b, EARLY ? 1 : 8);
    end
  endtask

  task automatic test_pattern();
    int ta, td;
    logic [1:0] a;
    data0 = 8'h10;
    req   = 2'b01;
    serve(ta, a);
    wait_done(td);
    total++;
    if (td - ta !== (EARLY ? 7 : 11) || hit_cnt !== 4'd1 || hit_pos !== 5'd3) begin
      bad++;
      $display("FAIL pattern_10: lat=%0d cnt=%0d pos=%0d, need %0d 1 3", td - ta, hit_cnt, hit_pos, EARLY ? 7 : 11);
    end
  endtask

  task automatic test_rst_mid();
    int ta, td;
    logic [1:0] a;
    bit saw_done;
    data0 = 8'h01;
    req   = 2'b01;
    serve(ta, a);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    total++;
    if (det_rst !== 1'b1) begin bad++; $display("FAIL rst_mid_det_rst: det_rst=%b, need 1", det_rst); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ack !== 2'b00 || done !== 1'b0 || det_x !== 1'b0 || done_id !== 1'b0 ||
        hit_cnt !== 4'd0 || hit_pos !== 5'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs: ack=%b done=%b x=%b id=%b cnt=%0d pos=%0d, need all 0",
               ack, done, det_x, done_id, hit_cnt, hit_pos);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin bad++; $display("FAIL rst_mid_dropped: done seen=%b, need 0", saw_done); end
    data1 = 8'h0F;
    req   = 2'b10;
    serve(ta, a);
    wait_done(td);
    total++;
    if (a !== 2'b10 || done_id !== 1'b1 || hit_cnt !== (EARLY ? 4'd1 : 4'd4) || hit_pos !== 5'd4) begin
      bad++;
      $display("FAIL rst_mid_after: ack=%b id=%b cnt=%0d pos=%0d, need 10 1 %0d 4",
               a, done_id, hit_cnt, hit_pos, EARLY ? 1 : 4);
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = 2'b00;
    data0 = 8'h00;
    data1 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_both();
    test_single();
    test_fair();
    test_saturate();
    test_pattern();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
